// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: opcode values (common with the
// function unit), instruction field positions and the ID/EX slot layout.
package decode_issue_stage_pkg;

  localparam int DEF_LINK_REG = 31;

  localparam int OPC_HI = 31, OPC_LO = 25;
  localparam int DR_HI  = 24, DR_LO  = 20;
  localparam int SA_HI  = 19, SA_LO  = 15;
  localparam int SB_HI  = 14, SB_LO  = 10;

  // Low nibble is the function-select code the function unit consumes as fs.
  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_MOVA = 7'h40;
  localparam logic [6:0] OP_ADD  = 7'h02;
  localparam logic [6:0] OP_SUB  = 7'h05;
  localparam logic [6:0] OP_AND  = 7'h08;
  localparam logic [6:0] OP_OR   = 7'h09;
  localparam logic [6:0] OP_XOR  = 7'h0A;
  localparam logic [6:0] OP_NOT  = 7'h0B;
  localparam logic [6:0] OP_MOVB = 7'h0C;
  localparam logic [6:0] OP_LSR  = 7'h0D;
  localparam logic [6:0] OP_LSL  = 7'h0E;
  localparam logic [6:0] OP_SLT  = 7'h65;
  localparam logic [6:0] OP_LD   = 7'h10;
  localparam logic [6:0] OP_ST   = 7'h20;
  localparam logic [6:0] OP_ADI  = 7'h42;
  localparam logic [6:0] OP_SBI  = 7'h45;
  localparam logic [6:0] OP_ANI  = 7'h48;
  localparam logic [6:0] OP_ORI  = 7'h49;
  localparam logic [6:0] OP_XRI  = 7'h4A;
  localparam logic [6:0] OP_AIU  = 7'h52;
  localparam logic [6:0] OP_SIU  = 7'h55;
  localparam logic [6:0] OP_BZ   = 7'h60;
  localparam logic [6:0] OP_BNZ  = 7'h61;
  localparam logic [6:0] OP_JMP  = 7'h44;
  localparam logic [6:0] OP_JML  = 7'h07;
  localparam logic [6:0] OP_JMR  = 7'h70;

  typedef enum logic [2:0] {BSEL_REG, BSEL_SIMM, BSEL_ZIMM, BSEL_BR, BSEL_JMP} bsel_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dr;
    logic        we;
    logic        mr;
    logic        mw;
    logic        br;
    logic [31:0] pc;
  } idex_t;

  function automatic logic [31:0] sext15(input logic [14:0] v);
    return {{17{v[14]}}, v};
  endfunction

  function automatic logic [31:0] sext25(input logic [24:0] v);
    return {{7{v[24]}}, v};
  endfunction

endpackage

// File: rtl/decode_issue_stage_hazard_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback or when an issued-but-unconsumed slot is flushed.
module decode_issue_stage_hazard_scoreboard #(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic       fclr_en,
  input  logic [4:0] fclr_addr,
  input  logic       qa_en,
  input  logic [4:0] qa_addr,
  input  logic       qb_en,
  input  logic [4:0] qb_addr,
  output logic       hazard
);
  logic [NREG-1:0] pend, pend_nxt;

  // Set is applied last so a same-cycle set/clear of one bit leaves it set.
  always_comb begin
    pend_nxt = pend;
    if (clr_en)  pend_nxt[clr_addr]  = 1'b0;
    if (fclr_en) pend_nxt[fclr_addr] = 1'b0;
    if (set_en)  pend_nxt[set_addr]  = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // Query the registered bits only: a writeback this cycle unblocks next cycle.
  assign hazard = (qa_en && qa_addr != 5'd0 && pend[qa_addr]) ||
                  (qb_en && qb_addr != 5'd0 && pend[qb_addr]);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes fetched words into function-unit operands and
// control, holding one ID/EX slot guarded by a RAW scoreboard.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_a_addr,
  output logic [4:0]  rf_b_addr,
  input  logic [31:0] rf_a_data,
  input  logic [31:0] rf_b_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [6:0]  ex_opcode,
  output logic [3:0]  ex_fs,
  output logic [4:0]  ex_sh,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_dr,
  output logic        ex_we,
  output logic        ex_mr,
  output logic        ex_mw,
  output logic        ex_br,
  output logic [31:0] ex_pc
);
  logic [6:0]  op;
  logic [4:0]  sa, sb, dest;
  logic        we, mr, mw, br, use_a, use_b;
  logic        hazard, accept, drop;
  bsel_e       bsel;
  logic [31:0] opb;
  idex_t       slot, dec;

  assign op        = in_instr[OPC_HI:OPC_LO];
  assign sa        = in_instr[SA_HI:SA_LO];
  assign sb        = in_instr[SB_HI:SB_LO];
  assign rf_a_addr = sa;
  assign rf_b_addr = sb;

  // Unknown opcodes fall to default and behave as NOP (no sources, no effects).
  always_comb begin
    we    = 1'b0;
    mr    = 1'b0;
    mw    = 1'b0;
    br    = 1'b0;
    use_a = 1'b1;
    use_b = 1'b0;
    bsel  = BSEL_REG;
    dest  = in_instr[DR_HI:DR_LO];
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin we = 1'b1; use_b = 1'b1; end
      OP_MOVA, OP_NOT, OP_LSR, OP_LSL:                we = 1'b1;
      OP_MOVB: begin we = 1'b1; use_a = 1'b0; use_b = 1'b1; end
      OP_ADI, OP_SBI:                                 begin we = 1'b1; bsel = BSEL_SIMM; end
      OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU:         begin we = 1'b1; bsel = BSEL_ZIMM; end
      OP_LD:   begin we = 1'b1; mr = 1'b1; end
      OP_ST:   begin mw = 1'b1; use_b = 1'b1; end
      OP_BZ, OP_BNZ: begin br = 1'b1; bsel = BSEL_BR; end
      OP_JMP:  begin br = 1'b1; use_a = 1'b0; bsel = BSEL_JMP; end
      OP_JML:  begin br = 1'b1; use_a = 1'b0; we = 1'b1; bsel = BSEL_JMP; dest = 5'(LINK_REG); end
      OP_JMR:  br = 1'b1;
      default: use_a = 1'b0;
    endcase
    if (dest == 5'd0) we = 1'b0;
  end

  always_comb begin
    case (bsel)
      BSEL_SIMM: opb = sext15(in_instr[14:0]);
      BSEL_ZIMM: opb = {17'd0, in_instr[14:0]};
      BSEL_BR:   opb = in_pc + sext15(in_instr[14:0]);
      BSEL_JMP:  opb = in_pc + sext25(in_instr[24:0]);
      default:   opb = rf_b_data;
    endcase
  end

  assign dec = '{opcode: op, sh: in_instr[4:0], a: (sa == 5'd0) ? 32'd0 : rf_a_data,
                 b: opb, dr: dest, we: we, mr: mr, mw: mw, br: br, pc: in_pc};

  assign in_ready = !rst && !hazard && !flush && (!ex_valid || ex_ready);
  assign accept   = in_valid && in_ready;
  // Flush only affects a slot EX has not taken this cycle.
  assign drop     = flush && ex_valid && !ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      slot     <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      slot     <= dec;
    end else if (drop || ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  decode_issue_stage_hazard_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && we),
    .set_addr  (dest),
    .clr_en    (wb_valid),
    .clr_addr  (wb_addr),
    .fclr_en   (drop && slot.we),
    .fclr_addr (slot.dr),
    .qa_en     (use_a),
    .qa_addr   (sa),
    .qb_en     (use_b),
    .qb_addr   (sb),
    .hazard    (hazard)
  );

  assign ex_opcode = slot.opcode;
  assign ex_fs     = slot.opcode[3:0];
  assign ex_sh     = slot.sh;
  assign ex_a      = slot.a;
  assign ex_b      = slot.b;
  assign ex_dr     = slot.dr;
  assign ex_we     = slot.we;
  assign ex_mr     = slot.mr;
  assign ex_mw     = slot.mw;
  assign ex_br     = slot.br;
  assign ex_pc     = slot.pc;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized + directed bench for decode_issue_stage against a cycle-level
// reference model of the decode rules, slot handshake and pending-write set.
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, wb_valid, flush, ex_valid, ex_ready;
  logic [31:0] in_instr, in_pc, rf_a_data, rf_b_data, ex_a, ex_b, ex_pc;
  logic [4:0]  rf_a_addr, rf_b_addr, wb_addr, ex_sh, ex_dr;
  logic [6:0]  ex_opcode;
  logic [3:0]  ex_fs;
  logic        ex_we, ex_mr, ex_mw, ex_br;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_fs(ex_fs), .ex_sh(ex_sh), .ex_a(ex_a), .ex_b(ex_b), .ex_dr(ex_dr), .ex_we(ex_we),
    .ex_mr(ex_mr), .ex_mw(ex_mw), .ex_br(ex_br), .ex_pc(ex_pc)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dr;
    logic        we, mr, mw, br, ua, ub;
    logic [31:0] pc;
  } ref_t;

  localparam logic [6:0] OPS [26] = '{OP_NOP, OP_MOVA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_NOT, OP_MOVB, OP_LSR, OP_LSL, OP_SLT, OP_LD, OP_ST, OP_ADI, OP_SBI, OP_ANI, OP_ORI,
    OP_XRI, OP_AIU, OP_SIU, OP_BZ, OP_BNZ, OP_JMP, OP_JML, OP_JMR};

  ref_t        m_slot = '0;
  bit          m_vld  = 1'b0;
  bit   [31:0] m_pend = '0;
  int          nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic ref_t mdec(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] ra, input logic [31:0] rb);
    ref_t d;
    logic [6:0] op;
    int imm, off;
    bit rr, wr, known;
    op  = ins[31:25];
    imm = int'(ins[14:0]);
    if (imm >= 16384) imm -= 32768;
    off = int'(ins[24:0]);
    if (off >= (1 << 24)) off -= (1 << 25);
    rr    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MOVB};
    wr    = rr || (op inside {OP_MOVA, OP_NOT, OP_LSR, OP_LSL, OP_LD, OP_JML, OP_ADI,
                              OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU});
    known = wr || (op inside {OP_NOP, OP_ST, OP_BZ, OP_BNZ, OP_JMP, OP_JMR});
    d.op = op;
    d.sh = ins[4:0];
    d.pc = pc;
    d.dr = (op == OP_JML) ? 5'd31 : ins[24:20];
    d.we = wr && (d.dr != 5'd0);
    d.mr = (op == OP_LD);
    d.mw = (op == OP_ST);
    d.br = op inside {OP_BZ, OP_BNZ, OP_JMP, OP_JML, OP_JMR};
    d.ua = known && !(op inside {OP_MOVB, OP_JMP, OP_JML, OP_NOP});
    d.ub = rr || (op == OP_ST);
    d.a  = (ins[19:15] == 5'd0) ? 32'd0 : ra;
    if (op inside {OP_ADI, OP_SBI})                         d.b = 32'(imm);
    else if (op inside {OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU}) d.b = {17'd0, ins[14:0]};
    else if (op inside {OP_BZ, OP_BNZ})                     d.b = pc + 32'(imm);
    else if (op inside {OP_JMP, OP_JML})                    d.b = pc + 32'(off);
    else                                                    d.b = rb;
    return d;
  endfunction

  // One clock: drive at negedge, check outputs, advance the model at posedge.
  task automatic cyc(input bit r, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] ra, input logic [31:0] rb, input bit wv,
                     input logic [4:0] wa, input bit fl, input bit er);
    ref_t d;
    bit haz, rdy, acc, drp;
    bit [31:0] nx;
    @(negedge clk);
    rst = r; in_valid = iv; in_instr = ins; in_pc = pc; rf_a_data = ra; rf_b_data = rb;
    wb_valid = wv; wb_addr = wa; flush = fl; ex_ready = er;
    #1;
    d   = mdec(ins, pc, ra, rb);
    haz = (d.ua && ins[19:15] != 5'd0 && m_pend[ins[19:15]]) ||
          (d.ub && ins[14:10] != 5'd0 && m_pend[ins[14:10]]);
    rdy = !r && !fl && !haz && (!m_vld || er);
    chk("in_ready",  32'(in_ready),  32'(rdy));
    chk("rf_a_addr", 32'(rf_a_addr), 32'(ins[19:15]));
    chk("rf_b_addr", 32'(rf_b_addr), 32'(ins[14:10]));
    chk("ex_valid",  32'(ex_valid),  32'(m_vld));
    chk("ex_opcode", 32'(ex_opcode), 32'(m_slot.op));
    chk("ex_fs",     32'(ex_fs),     32'(m_slot.op) % 16);
    chk("ex_sh",     32'(ex_sh),     32'(m_slot.sh));
    chk("ex_a",      ex_a,           m_slot.a);
    chk("ex_b",      ex_b,           m_slot.b);
    chk("ex_dr",     32'(ex_dr),     32'(m_slot.dr));
    chk("ex_we",     32'(ex_we),     32'(m_slot.we));
    chk("ex_mr",     32'(ex_mr),     32'(m_slot.mr));
    chk("ex_mw",     32'(ex_mw),     32'(m_slot.mw));
    chk("ex_br",     32'(ex_br),     32'(m_slot.br));
    chk("ex_pc",     ex_pc,          m_slot.pc);
    chk("pending",   dut.u_sb.pend,  m_pend);
    @(posedge clk);
    acc = iv && rdy;
    drp = fl && m_vld && !er;
    if (r) begin
      m_vld = 1'b0; m_slot = '0; m_pend = '0;
    end else begin
      nx = m_pend;
      if (wv) nx[wa] = 1'b0;
      if (drp && m_slot.we) nx[m_slot.dr] = 1'b0;
      if (acc && d.we) nx[d.dr] = 1'b1;
      nx[0] = 1'b0;
      m_pend = nx;
      if (acc) begin m_slot = d; m_vld = 1'b1; end
      else if (drp || er) m_vld = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] rrr(input logic [6:0] op, input logic [4:0] dr,
                                      input logic [4:0] sa, input logic [4:0] sb);
    return {op, dr, sa, sb, 10'd0};
  endfunction

  function automatic logic [31:0] rri(input logic [6:0] op, input logic [4:0] dr,
                                      input logic [4:0] sa, input logic [14:0] imm);
    return {op, dr, sa, imm};
  endfunction

  task automatic idle(input bit er, input bit fl);
    cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 5'd0, fl, er);
  endtask

  initial begin
    logic [31:0] snap;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; rf_a_data = '0; rf_b_data = '0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0; ex_ready = 1'b0;
    repeat (2) @(posedge clk);
    repeat (2) cyc(1'b1, 1'b1, rrr(OP_ADD, 5'd3, 5'd1, 5'd2), '0, '0, '0, 1'b0, 5'd0, 1'b0, 1'b1);

    // ADD R3,R1,R2
    cyc(1'b0, 1'b1, rrr(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h40, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_op",    32'(ex_opcode), 32'(OP_ADD));
    chk("add_a",     ex_a, 32'd5);
    chk("add_b",     ex_b, 32'd7);
    chk("add_dr",    32'(ex_dr), 32'd3);
    chk("add_we",    32'(ex_we), 32'd1);
    chk("add_sb3",   32'(dut.u_sb.pend[3]), 32'd1);

    // SUB R5,R3,R2 waits on R3 until the cycle after its writeback
    repeat (2) cyc(1'b0, 1'b1, rrr(OP_SUB, 5'd5, 5'd3, 5'd2), 32'h44, 32'd9, 32'd1, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("raw_stall_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b1, rrr(OP_SUB, 5'd5, 5'd3, 5'd2), 32'h44, 32'd9, 32'd1, 1'b1, 5'd3, 1'b0, 1'b1);
    chk("raw_wb_no_issue", 32'(ex_valid), 32'd0);
    cyc(1'b0, 1'b1, rrr(OP_SUB, 5'd5, 5'd3, 5'd2), 32'h44, 32'd9, 32'd1, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("raw_issue_op", 32'(ex_opcode), 32'(OP_SUB));
    chk("raw_issue_dr", 32'(ex_dr), 32'd5);

    // Immediate extension
    cyc(1'b0, 1'b1, rri(OP_ADI, 5'd4, 5'd1, 15'h7FFF), 32'h48, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("adi_sext", ex_b, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, rri(OP_ANI, 5'd4, 5'd1, 15'h7FFF), 32'h4C, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("ani_zext", ex_b, 32'h0000_7FFF);

    // Backpressure holds the slot; release gives back-to-back issue
    snap = ex_pc;
    repeat (3) begin
      cyc(1'b0, 1'b1, rrr(OP_XOR, 5'd7, 5'd1, 5'd2), 32'h50, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("hold_op", 32'(ex_opcode), 32'(OP_ANI));
      chk("hold_pc", ex_pc, snap);
    end
    cyc(1'b0, 1'b1, rrr(OP_XOR, 5'd7, 5'd1, 5'd2), 32'h50, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("b2b_xor", 32'(ex_opcode), 32'(OP_XOR));
    cyc(1'b0, 1'b1, rrr(OP_OR, 5'd8, 5'd1, 5'd2), 32'h54, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("b2b_or", 32'(ex_opcode), 32'(OP_OR));

    // Flush a stalled LD
    cyc(1'b0, 1'b1, rrr(OP_LD, 5'd6, 5'd1, 5'd0), 32'h58, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    chk("ld_pend6", 32'(dut.u_sb.pend[6]), 32'd1);
    idle(1'b0, 1'b1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_pend6", 32'(dut.u_sb.pend[6]), 32'd0);
    cyc(1'b0, 1'b1, rrr(OP_MOVA, 5'd9, 5'd1, 5'd0), 32'h5C, 32'd3, 32'd4, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("flush_blocks", 32'(ex_valid), 32'd0);

    // JML link and target
    cyc(1'b0, 1'b1, {OP_JML, 25'h10}, 32'h100, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("jml_b",  ex_b, 32'h110);
    chk("jml_dr", 32'(ex_dr), 32'd31);
    chk("jml_br", 32'(ex_br), 32'd1);
    chk("jml_we", 32'(ex_we), 32'd1);

    // Writes to R0 are suppressed
    snap = dut.u_sb.pend;
    cyc(1'b0, 1'b1, rrr(OP_ADD, 5'd0, 5'd1, 5'd2), 32'h104, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("r0_we",   32'(ex_we), 32'd0);
    chk("r0_pend", dut.u_sb.pend, snap);

    for (int r = 1; r < 32; r++) cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 5'(r), 1'b0, 1'b1);

    // Random traffic over a small register window to provoke hazards
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ins;
      logic [4:0]  wa;
      int          q[$];
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[31:25] = OPS[$urandom_range(0, 25)];
      if ($urandom_range(0, 3) != 0) begin
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[14:10] = 5'($urandom_range(0, 7));
      end
      q = {};
      for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
      wa = (q.size() > 0 && $urandom_range(0, 4) != 0) ? 5'(q[$urandom_range(0, q.size() - 1)])
                                                       : 5'($urandom);
      cyc(k == 400, $urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom,
          $urandom_range(0, 2) == 0, wa, $urandom_range(0, 12) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset while busy drops everything
    cyc(1'b0, 1'b1, rrr(OP_ADD, 5'd10, 5'd0, 5'd0), 32'h200, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, rrr(OP_ADD, 5'd11, 5'd0, 5'd0), 32'h204, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pend",  dut.u_sb.pend, 32'd0);
    chk("rst_b",     ex_b, 32'd0);
    idle(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/issue stage that drives the CPU function unit: takes fetched instruction words and produces the function unit's operation inputs (opcode, fs, sh, a, b) plus writeback/memory control.
- Holds one registered ID/EX slot with valid/ready handshakes on both sides.
- Contains a 32-entry pending-write scoreboard that stalls RAW hazards until writeback.
- Sits between fetch and the function unit; opcode values come from the shared opcode defines.

Parameters:
- NREG, 32, number of architectural registers; R0 is hardwired zero.
- LINK_REG, 31, destination register written by JML.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  PC of in_instr
- rf_a_addr  out  5  register-file read address A (combinational, equals in_instr[19:15])
- rf_b_addr  out  5  register-file read address B (in_instr[14:10])
- rf_a_data  in  32  read data A, same cycle
- rf_b_data  in  32  read data B, same cycle
- wb_valid  in  1  writeback retiring this cycle
- wb_addr  in  5  register retired
- flush  in  1  discard the un-accepted ID/EX slot
- ex_valid  out  1  ID/EX slot valid
- ex_ready  in  1  function unit accepts
- ex_opcode  out  7  to function unit opcode
- ex_fs  out  4  ex_opcode[3:0]
- ex_sh  out  5  shift amount, instr[4:0]
- ex_a  out  32  operand A
- ex_b  out  32  operand B or immediate
- ex_dr  out  5  destination register
- ex_we  out  1  register write enable
- ex_mr  out  1  load
- ex_mw  out  1  store
- ex_br  out  1  BZ/BNZ/JMP/JML/JMR
- ex_pc  out  32  PC of slot

Behaviour:
- Format: opcode[31:25], DR[24:20], SA[19:15], SB[14:10], IMM15[14:0], OFF25[24:0].
- Operand B:
  - ADI/SBI: sign-extended IMM15.
  - ANI/ORI/XRI/AIU/SIU: zero-extended IMM15.
  - BZ/BNZ: in_pc + sext(IMM15).
  - JMP/JML: in_pc + sext(OFF25).
  - Otherwise: rf_b_data.
- Operand A: rf_a_data; 0 when SA==0.
- Write enable:
  - ex_we=1 for ALU/immediate/MOVA/MOVB/NOT/LSR/LSL/SLT/LD/JML.
  - ex_we forced 0 when dest==0.
  - JML dest = LINK_REG.
  - ST/BZ/BNZ/JMP/JMR/NOP have ex_we=0.
- Unknown opcode decodes as NOP: ex_we=0, ex_mr=0, ex_mw=0, ex_br=0.
- Sources used:
  - A for all opcodes except MOVB/JMP/JML/NOP.
  - B only for register-register ops and ST.
- Hazard: stall when a used source register (nonzero) has its scoreboard bit set.
- in_ready = !rst && !hazard && (!ex_valid || ex_ready).
- Same-cycle wb clear does not unblock; issue occurs the following cycle.
- Accept (in_valid && in_ready): on the next edge, load the slot, set ex_valid=1, and set scoreboard[dest] if ex_we.
- Slot drain: ex_valid && ex_ready with no new accept → ex_valid=0 next cycle.
- Slot outputs are held stable while ex_valid && !ex_ready.
- Scoreboard:
  - wb_valid clears bit wb_addr.
  - Simultaneous set and clear of the same bit: set wins.
  - Bit 0 is never set.
- Flush:
  - If ex_valid && !ex_ready: the slot is dropped (ex_valid=0 next cycle) and its scoreboard bit (if ex_we) is cleared.
  - Flush also blocks acceptance that cycle (in_ready=0).
  - A slot accepted by EX that same cycle is not affected.
- Latency: one cycle from accept to ex_valid.
- Throughput: one instruction per cycle absent hazards.
- Reset: ex_valid=0, all ex_* data outputs 0, scoreboard all 0, in_ready=0 during reset. Reset mid-operation discards the slot and all pending bits.

Decomposition:
- Shared defines: opcode constants (already used by the function unit), field bit positions, LINK_REG.
- One natural sub-module: hazard_scoreboard (32-bit set/clear/query, set-wins rule, flush clear). Decode logic stays in the top.

Test Plan:
- Reset, then ADD R3,R1,R2 with rf_a=5, rf_b=7 → ex_valid next cycle, ex_opcode=ADD, ex_a=5, ex_b=7, ex_dr=3, ex_we=1, scoreboard[3]=1.
- ADI R4,R1,imm 0x7FFF (negative) → ex_b=0xFFFFFFFF. ANI with the same imm → ex_b=0x00007FFF.
- ADD R3,... then SUB R5,R3,R2 back-to-back → in_ready=0 until the cycle after wb_valid with wb_addr=3; SUB then issues once.
- Hold ex_ready=0 for 3 cycles with the slot valid → outputs stable, in_ready=0. Then ex_ready=1 plus a new in_valid → back-to-back issue.
- Slot LD R6 stalled by ex_ready=0, then flush=1 → ex_valid=0 next cycle, scoreboard[6]=0.
- JML at in_pc=0x100, OFF25=0x10 → ex_b=0x110, ex_dr=31, ex_br=1. Any write to dest 0 → ex_we=0, no scoreboard change.
